// File: rtl/lcd_responder.sv
// HD44780-style LCD controller model: decodes writer strobes, keeps 80-byte DDRAM, cursor and mode flags.
// Latency: a transaction takes effect one cycle after its synchronized falling edge is detected.
// Backpressure: busy is high during EXEC/CLEAR; strobes arriving then are dropped and flag err.
module lcd_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1520
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic [7:0] data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       incr_mode,
    output logic       shift_mode,
    output logic       busy,
    output logic       cmd_valid,
    output logic       char_valid,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    localparam logic [15:0] EXEC_LAST  = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] FILL_LEN   = 16'd80;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        e_s1, e_s2, e_prev, rs_s1, rs_s2;
    logic [7:0]  d_s1, d_s2;
    logic [7:0]  mem [0:79];
    logic        fall, accept, is_clear, fill_we, data_we;

    // Address is inside the DDRAM window for the current line mode
    function automatic logic is_mapped(input logic [6:0] a, input logic two);
        if (two) return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
        return a <= 7'h4F;
    endfunction

    // Linear storage index; line 2 of two-line mode sits after the 40 bytes of line 1
    function automatic logic [6:0] to_idx(input logic [6:0] a, input logic two);
        if (two && a[6]) return {1'b0, a[5:0]} + 7'd40;
        return a;
    endfunction

    // Cursor step with the line-mode wrap points
    function automatic logic [6:0] step(input logic [6:0] a, input logic inc, input logic two);
        if (two) begin
            if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
        end
        if (inc) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    assign busy     = (state != IDLE);
    assign fall     = e_prev && !e_s2;
    assign accept   = fall && !busy;
    assign is_clear = !rs_s2 && (d_s2 == 8'h01);
    assign fill_we  = (state == CLEAR) && (cnt < FILL_LEN);
    assign data_we  = accept && rs_s2 && is_mapped(cursor_addr, two_line);
    assign rd_char  = is_mapped(rd_addr, two_line) ? mem[to_idx(rd_addr, two_line)] : 8'h00;

    // State register; reset parks in CLEAR so release always starts a fresh fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nxt;
    end

    // Next-state: accepted strobes start EXEC or CLEAR, timers return to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_clear ? CLEAR : EXEC;
            EXEC:    if (cnt == EXEC_LAST) state_nxt = IDLE;
            CLEAR:   if (cnt == CLEAR_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Synchronizers, busy timer, cursor, flags and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_s1 <= 1'b0;  e_s2 <= 1'b0;  e_prev <= 1'b0;
            rs_s1 <= 1'b0; rs_s2 <= 1'b0;
            d_s1 <= 8'h00; d_s2 <= 8'h00;
            cnt <= 16'd0;
            cursor_addr <= 7'h00;
            disp_on <= 1'b0; cursor_on <= 1'b0; blink_on <= 1'b0;
            two_line <= 1'b0; shift_mode <= 1'b0; incr_mode <= 1'b1;
            err <= 1'b0;
            cmd_valid <= 1'b0; char_valid <= 1'b0;
        end else begin
            e_s1 <= lcd_e;   e_s2 <= e_s1;   e_prev <= e_s2;
            rs_s1 <= lcd_rs; rs_s2 <= rs_s1;
            d_s1 <= data;    d_s2 <= d_s1;
            cmd_valid  <= 1'b0;
            char_valid <= 1'b0;

            if (state_nxt != state) cnt <= 16'd0;
            else if (busy)          cnt <= cnt + 16'd1;

            if (fall && busy) err <= 1'b1;

            if (accept) begin
                if (rs_s2) begin
                    char_valid  <= 1'b1;
                    cursor_addr <= step(cursor_addr, incr_mode, two_line);
                end else begin
                    cmd_valid <= 1'b1;
                    casez (d_s2)
                        8'b1???????: begin
                            if (is_mapped(d_s2[6:0], two_line)) cursor_addr <= d_s2[6:0];
                            else                                err <= 1'b1;
                        end
                        8'b01??????: ;
                        8'b001?????: two_line <= d_s2[3];
                        8'b0001????: if (!d_s2[3]) cursor_addr <= step(cursor_addr, d_s2[2], two_line);
                        8'b00001???: begin
                            disp_on   <= d_s2[2];
                            cursor_on <= d_s2[1];
                            blink_on  <= d_s2[0];
                        end
                        8'b000001??: begin
                            incr_mode  <= d_s2[1];
                            shift_mode <= d_s2[0];
                        end
                        8'b0000001?: cursor_addr <= 7'h00;
                        8'b00000001: begin
                            cursor_addr <= 7'h00;
                            incr_mode   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // DDRAM: clear fill has priority; a data write cannot coincide with CLEAR anyway
    always_ff @(posedge clk) begin
        if (fill_we)      mem[cnt[6:0]] <= 8'h20;
        else if (data_we) mem[to_idx(cursor_addr, two_line)] <= d_s2;
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: init sequence, data writes, wraps, errors, reset mid-fill.
// Latency: checks sample #1 after the edge on which a strobe takes effect.
// Backpressure: drives strobes only when idle except for the deliberate dropped-write case.
module tb_lcd_responder;

    localparam int BC = 20;
    localparam int CC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic [7:0] data = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       disp_on, cursor_on, blink_on, two_line, incr_mode, shift_mode;
    logic       busy, cmd_valid, char_valid, err;

    int n_cmp = 0;
    int n_err = 0;
    int char_cnt = 0;

    lcd_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .data(data),
        .rd_addr(rd_addr), .rd_char(rd_char), .cursor_addr(cursor_addr),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .incr_mode(incr_mode), .shift_mode(shift_mode),
        .busy(busy), .cmd_valid(cmd_valid), .char_valid(char_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (char_valid === 1'b1) char_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe; returns at the cycle its effect is visible, with the pulses seen then
    task automatic wr(input logic rs, input logic [7:0] d, output logic pc, output logic pd);
        @(negedge clk);
        lcd_rs = rs; data = d; lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pc = cmd_valid;
        pd = char_valid;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_idle"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic cmd(input logic [7:0] d);
        logic pc, pd;
        int n;
        wr(1'b0, d, pc, pd);
        check($sformatf("cmd_valid_%02h", d), {pc, pd}, 2'b10);
        wait_idle("cmd", n);
    endtask

    task automatic chr(input logic [7:0] d);
        logic pc, pd;
        int n;
        wr(1'b1, d, pc, pd);
        check($sformatf("char_valid_%02h", d), {pc, pd}, 2'b01);
        wait_idle("chr", n);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        rd_addr = a;
        #1;
        v = rd_char;
    endtask

    task automatic check_fill(input string tag, input logic two);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            peek(two ? ((i < 40) ? 7'(i) : 7'(i + 24)) : 7'(i), v);
            if (v !== 8'h20) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic pc, pd;
        logic [7:0] v;
        int n, base;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_flags", {disp_on, cursor_on, blink_on, two_line, incr_mode, shift_mode}, 6'b000010);
        check("rst_pulses_err", {cmd_valid, char_valid, err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("busy_after_release", busy, 1'b1);
        wait_idle("init", n);
        check_fill("fill_after_reset", 1'b0);

        // Initialisation sequence
        wr(1'b0, 8'h38, pc, pd);
        check("cmd_38_pulse", {pc, pd}, 2'b10);
        @(posedge clk); #1;
        check("cmd_pulse_one_cycle", cmd_valid, 1'b0);
        n = 1;
        while (busy === 1'b1 && n < 5000) begin n++; @(posedge clk); #1; end
        check("exec_busy_len", n, BC);
        check("two_line", two_line, 1'b1);
        cmd(8'h0C);
        check("display_ctrl", {disp_on, cursor_on, blink_on}, 3'b100);
        cmd(8'h06);
        check("entry_mode", {incr_mode, shift_mode}, 2'b10);
        wr(1'b0, 8'h01, pc, pd);
        check("cmd_01_pulse", {pc, pd}, 2'b10);
        wait_idle("clear", n);
        check("clear_busy_len", n, CC);
        cmd(8'h80);
        check("cursor_home_80", cursor_addr, 7'h00);
        check_fill("fill_after_clear", 1'b1);

        // Four characters
        base = char_cnt;
        chr(8'h30); chr(8'h78); chr(8'h37); chr(8'h38);
        peek(7'h00, v); check("rd_00", v, 8'h30);
        peek(7'h01, v); check("rd_01", v, 8'h78);
        peek(7'h02, v); check("rd_02", v, 8'h37);
        peek(7'h03, v); check("rd_03", v, 8'h38);
        check("cursor_after_4", cursor_addr, 7'h04);
        check("char_pulses", char_cnt - base, 4);

        // Two-line wraps
        cmd(8'hA7);
        check("cursor_27", cursor_addr, 7'h27);
        chr(8'h41);
        peek(7'h27, v); check("rd_27", v, 8'h41);
        check("wrap_27_40", cursor_addr, 7'h40);
        cmd(8'h04);
        check("entry_decr", {incr_mode, shift_mode}, 2'b00);
        cmd(8'h80);
        chr(8'h42);
        peek(7'h00, v); check("rd_00_b", v, 8'h42);
        check("wrap_00_67", cursor_addr, 7'h67);
        peek(7'h30, v); check("rd_unmapped_30", v, 8'h00);
        check("err_clean", err, 1'b0);

        // One-line addressing
        cmd(8'h30);
        check("one_line", two_line, 1'b0);
        cmd(8'hC0);
        check("one_line_40_ok", {cursor_addr, err}, {7'h40, 1'b0});
        cmd(8'hD0);
        check("unmapped_addr", {cursor_addr, err}, {7'h40, 1'b1});
        cmd(8'h10);
        check("shift_left", cursor_addr, 7'h3F);

        // Fresh reset, then dropped second strobe
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        wait_idle("reset2", n);
        check("err_cleared", err, 1'b0);
        cmd(8'h10);
        check("wrap_00_4f", cursor_addr, 7'h4F);
        cmd(8'h14);
        check("wrap_4f_00", cursor_addr, 7'h00);
        base = char_cnt;
        wr(1'b1, 8'h55, pc, pd);
        wr(1'b1, 8'h66, pc, pd);
        check("dropped_no_pulse", {pc, pd}, 2'b00);
        wait_idle("drop", n);
        peek(7'h00, v); check("rd_first_kept", v, 8'h55);
        peek(7'h01, v); check("rd_dropped_absent", v, 8'h20);
        check("cursor_after_drop", cursor_addr, 7'h01);
        check("drop_char_count", char_cnt - base, 1);
        check("drop_err", err, 1'b1);

        // Reset 20 cycles into a clear fill
        cmd(8'hCE);
        chr(8'h77);
        peek(7'h4E, v); check("rd_4e_pre", v, 8'h77);
        cmd(8'h0F);
        wr(1'b0, 8'h01, pc, pd);
        repeat (20) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midfill_rst_flags", {disp_on, cursor_on, blink_on, two_line, incr_mode, shift_mode}, 6'b000010);
        check("midfill_rst_cursor_err", {cursor_addr, err, cmd_valid, char_valid}, {7'h00, 3'b000});
        repeat (3) @(negedge clk); rst_n = 1'b1;
        #1;
        check("midfill_busy", busy, 1'b1);
        wait_idle("midfill", n);
        check_fill("fill_after_midfill_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
